// File: rtl/ball_pkg.sv
// ball_pkg: shared state encoding and default screen bounds for the ball mover
package ball_pkg;
    typedef enum logic [1:0] {HOLD = 2'd0, MOVE = 2'd1, LOST = 2'd2} state_t;
    localparam int SCREEN_X_MAX = 312;
    localparam int SCREEN_Y_MAX = 232;
endpackage

// File: rtl/ball_axis.sv
// ball_axis: one axis position/direction register with step, flip, clamp and bounce
module ball_axis
    import ball_pkg::*;
#(
    parameter int   W       = 10,
    parameter int   STEP_W  = 3,
    parameter int   MAX     = SCREEN_X_MAX,
    parameter int   INIT    = 156,
    parameter logic INIT_DU = 1'b1,
    parameter logic HI_STOP = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [W-1:0]      load_p,
    input  logic              load_du,
    input  logic              move,
    input  logic [STEP_W-1:0] step,
    input  logic              flip,
    output logic [W-1:0]      p,
    output logic              du,
    output logic              bounce_lo,
    output logic              bounce_hi
);
    localparam logic [W:0]   MAX_E  = (W+1)'(MAX);
    localparam logic [W-1:0] MAX_P  = W'(MAX);
    localparam logic [W-1:0] INIT_P = W'(INIT);

    logic [W-1:0] p_q, p_d;
    logic         du_q, du_d;
    logic         eff;
    logic [W:0]   step_e, sum;

    always_comb begin
        eff       = du_q ^ flip;
        step_e    = (W+1)'(step);
        sum       = {1'b0, p_q} + step_e;
        bounce_hi = move & eff & (sum >= MAX_E);
        bounce_lo = move & ~eff & ({1'b0, p_q} <= step_e);
        p_d       = load ? load_p : !move ? p_q : bounce_hi ? MAX_P : bounce_lo ? '0 :
                    eff ? sum[W-1:0] : p_q - step_e[W-1:0];
        // HI_STOP keeps the direction on a high clamp (bottom wall ends play instead of bouncing)
        du_d      = load ? load_du : bounce_hi ? HI_STOP : bounce_lo ? 1'b1 : eff;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            p_q  <= INIT_P;
            du_q <= INIT_DU;
        end else begin
            p_q  <= p_d;
            du_q <= du_d;
        end
    end

    assign p  = p_q;
    assign du = du_q;
endmodule

// File: rtl/ball_motion.sv
// ball_motion: two-axis ball mover with wall bounces, bottom loss and load/launch control
module ball_motion
    import ball_pkg::*;
#(
    parameter int W      = 10,
    parameter int STEP_W = 3,
    parameter int X_MAX  = SCREEN_X_MAX,
    parameter int Y_MAX  = SCREEN_Y_MAX,
    parameter int X_INIT = 156,
    parameter int Y_INIT = 200
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              load,
    input  logic [W-1:0]      load_x,
    input  logic [W-1:0]      load_y,
    input  logic              load_xdu,
    input  logic              load_ydu,
    input  logic              launch,
    input  logic [STEP_W-1:0] step_x,
    input  logic [STEP_W-1:0] step_y,
    input  logic              flip_x,
    input  logic              flip_y,
    output logic [W-1:0]      x,
    output logic [W-1:0]      y,
    output logic              x_du,
    output logic              y_du,
    output logic              hit_wall,
    output logic              lost,
    output logic              moving
);
    state_t state_q, state_d;
    logic   hit_wall_q, hit_wall_d;
    logic   move;
    logic   x_lo, x_hi, y_lo, y_hi;

    assign move = enable & ~load & (state_q == MOVE);

    ball_axis #(
        .W(W), .STEP_W(STEP_W), .MAX(X_MAX), .INIT(X_INIT), .INIT_DU(1'b1), .HI_STOP(1'b0)
    ) u_x (
        .clk(clk), .resetn(resetn), .load(load), .load_p(load_x), .load_du(load_xdu),
        .move(move), .step(step_x), .flip(flip_x), .p(x), .du(x_du),
        .bounce_lo(x_lo), .bounce_hi(x_hi)
    );

    ball_axis #(
        .W(W), .STEP_W(STEP_W), .MAX(Y_MAX), .INIT(Y_INIT), .INIT_DU(1'b0), .HI_STOP(1'b1)
    ) u_y (
        .clk(clk), .resetn(resetn), .load(load), .load_p(load_y), .load_du(load_ydu),
        .move(move), .step(step_y), .flip(flip_y), .p(y), .du(y_du),
        .bounce_lo(y_lo), .bounce_hi(y_hi)
    );

    always_comb begin
        state_d    = load ? HOLD : (state_q == HOLD && launch) ? MOVE :
                     (move && y_hi) ? LOST : state_q;
        hit_wall_d = move & (x_lo | x_hi | y_lo) & ~y_hi;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= HOLD;
            hit_wall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hit_wall_q <= hit_wall_d;
        end
    end

    assign hit_wall = hit_wall_q;
    assign moving   = (state_q == MOVE);
    assign lost     = (state_q == LOST);
endmodule
